// File: rtl/paquete_cpu.sv
// Shared definitions for the CPU pipeline: fetch state encoding,
// instruction geometry and the halt opcode.
package paquete_cpu;

  // Fetch stage control states
  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    EJECUTA  = 2'd1,
    DETENIDO = 2'd2
  } estado_t;

  // Instructions are four bytes wide and word aligned
  localparam int         PASO_INSTR  = 4;
  localparam int         ANCHO_INSTR = 32;
  localparam logic [7:0] OPC_HALT    = 8'hFF;

  // Forces a byte address onto an instruction boundary
  function automatic logic [7:0] alinear(input logic [7:0] dir);
    return {dir[7:2], 2'b00};
  endfunction

endpackage

// File: rtl/contador_sat.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module contador_sat #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [width-1:0] q
);

  logic [width-1:0] q_reg;

  // Count on inc, but never roll over from the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else if (inc && (q_reg != {width{1'b1}})) begin
      q_reg <= q_reg + 1'b1;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/etapa_fetch.sv
// Instruction-fetch stage: owns the PC, addresses the 4-byte instruction
// memory, latches the returned word into the IR and offers it to decode
// through a valid/ready handshake. Handles branch redirect, stall, halt.
module etapa_fetch #(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter logic [7:0] OPC_HALT = paquete_cpu::OPC_HALT,
  parameter int         PASO     = paquete_cpu::PASO_INSTR
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  output logic [7:0]                          Direccion,
  input  logic [7:0]                          B1,
  input  logic [7:0]                          B2,
  input  logic [7:0]                          B3,
  input  logic [7:0]                          B4,
  input  logic                                salto,
  input  logic [7:0]                          salto_dir,
  output logic [paquete_cpu::ANCHO_INSTR-1:0] ir,
  output logic [7:0]                          ir_pc,
  output logic                                ir_valid,
  input  logic                                ir_ready,
  output logic                                detenido,
  output logic                                err_alin,
  output logic [15:0]                         cont_instr
);

  import paquete_cpu::*;

  localparam logic [7:0] PASO8 = 8'(PASO);

  estado_t                estado_reg, estado_next;
  logic [7:0]             pc_reg, pc_next;
  logic [ANCHO_INSTR-1:0] ir_reg, ir_next;
  logic [7:0]             ir_pc_reg, ir_pc_next;
  logic                   ir_valid_reg, ir_valid_next;
  logic                   err_alin_reg, err_alin_next;

  logic                   carga;
  logic                   redirige;
  logic                   es_halt;
  logic [ANCHO_INSTR-1:0] palabra;
  logic [7:0]             bytes_mem [4];

  assign bytes_mem[0] = B1;
  assign bytes_mem[1] = B2;
  assign bytes_mem[2] = B3;
  assign bytes_mem[3] = B4;

  // B1 is the most significant byte of the instruction word
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bytes
      assign palabra[ANCHO_INSTR-1-8*gi -: 8] = bytes_mem[gi];
    end
  endgenerate

  // Redirect beats everything; otherwise load whenever the IR is free or
  // being consumed on this same edge
  assign redirige = (estado_reg == EJECUTA) && salto;
  assign carga    = (estado_reg == EJECUTA) && !salto && (!ir_valid_reg || ir_ready);
  assign es_halt  = (palabra[ANCHO_INSTR-1 -: 8] == OPC_HALT);

  // Next-state, PC and IR update logic
  always_comb begin
    estado_next   = estado_reg;
    pc_next       = pc_reg;
    ir_next       = ir_reg;
    ir_pc_next    = ir_pc_reg;
    ir_valid_next = ir_valid_reg;
    err_alin_next = err_alin_reg;

    // A completed handshake empties the IR unless a new word replaces it
    if (ir_valid_reg && ir_ready) begin
      ir_valid_next = 1'b0;
    end

    case (estado_reg)
      ESPERA: begin
        if (en) begin
          estado_next = EJECUTA;
        end
      end

      EJECUTA: begin
        if (redirige) begin
          pc_next       = alinear(salto_dir);
          ir_valid_next = 1'b0;
          if (salto_dir[1:0] != 2'b00) begin
            err_alin_next = 1'b1;
          end
        end else if (carga) begin
          ir_next       = palabra;
          ir_pc_next    = pc_reg;
          ir_valid_next = 1'b1;
          pc_next       = pc_reg + PASO8;
        end

        // A latched halt takes precedence over dropping the enable
        if (carga && es_halt) begin
          estado_next = DETENIDO;
        end else if (!en) begin
          estado_next = ESPERA;
        end
      end

      DETENIDO: begin
        estado_next = DETENIDO;
      end

      default: begin
        estado_next = ESPERA;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_reg   <= ESPERA;
      pc_reg       <= PC_RESET;
      ir_reg       <= '0;
      ir_pc_reg    <= '0;
      ir_valid_reg <= 1'b0;
      err_alin_reg <= 1'b0;
    end else begin
      estado_reg   <= estado_next;
      pc_reg       <= pc_next;
      ir_reg       <= ir_next;
      ir_pc_reg    <= ir_pc_next;
      ir_valid_reg <= ir_valid_next;
      err_alin_reg <= err_alin_next;
    end
  end

  contador_sat #(
    .width (16)
  ) u_contador (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (carga),
    .q     (cont_instr)
  );

  assign Direccion = pc_reg;
  assign ir        = ir_reg;
  assign ir_pc     = ir_pc_reg;
  assign ir_valid  = ir_valid_reg;
  assign detenido  = (estado_reg == DETENIDO);
  assign err_alin  = err_alin_reg;

endmodule
